sys_array_os: RTL and testbench

- Output-stationary, parametrised systolic GEMM tile, successor to the current weight/feature systolic array.
- Computes C[r][c] = sum over k of W[r][k]*F[k][c] for a ROWS x COLS tile over a run-time reduction length k_len.
- Adds internal input skewing, valid/ready handshakes on both sides, a flush/drain state machine, signed wrap-around accumulation and optional ReLU.
- Sits between the weight/feature buffers and the aggregation/output buffer of the GCN datapath.

---
 rtl/sys_array_pkg.sv | 29 ++
 rtl/sys_pe_os.sv | 49 ++++
 rtl/sys_array_os.sv | 204 ++++++++++++++++++++
 tb/tb_sys_array_os.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared encodings and arithmetic helpers for the output-stationary systolic GEMM tile.
package sys_array_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Widest accumulator the helpers support; ACC_W must not exceed this.
    localparam int unsigned MAX_W = 64;
    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sign-extend the low w bits of x to the full wide_t width.
    function automatic wide_t sext(input wide_t x, input int unsigned w);
        int unsigned sh;
        sh = MAX_W - w;
        return (x <<< sh) >>> sh;
    endfunction

    // Clamp a w-bit two's complement value to zero if negative.
    function automatic wide_t relu(input wide_t x, input int unsigned w);
        return x[w-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/sys_pe_os.sv
// Output-stationary PE: forwards weight right and feature down, accumulates their product.
module sys_pe_os
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic [DATA_W-1:0] f_i,
    output logic [DATA_W-1:0] w_o,
    output logic [DATA_W-1:0] f_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] w_ext, f_ext;
    logic        [2*DATA_W-1:0] prod;
    logic        [DATA_W-1:0]   w_q, f_q;
    logic        [ACC_W-1:0]    acc_q, acc_d;

    assign w_ext = (2*DATA_W)'($signed(w_i));
    assign f_ext = (2*DATA_W)'($signed(f_i));
    assign prod  = w_ext * f_ext;
    assign acc_d = acc_q + ACC_W'(sext(wide_t'(prod), 2*DATA_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q   <= '0;
            f_q   <= '0;
            acc_q <= '0;
        end else if (clr_i) begin
            w_q   <= '0;
            f_q   <= '0;
            acc_q <= '0;
        end else if (adv_i) begin
            w_q   <= w_i;
            f_q   <= f_i;
            acc_q <= acc_d;
        end
    end

    assign w_o   = w_q;
    assign f_o   = f_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/sys_array_os.sv
// ROWS x COLS output-stationary systolic GEMM tile with input skew, flush and row drain.
module sys_array_os
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned K_MAX  = 256,
    parameter int unsigned K_W    = $clog2(K_MAX+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     relu_en,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   w_col,
    input  logic [COLS*DATA_W-1:0]   f_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*ACC_W-1:0]    out_row,
    output logic [$clog2(ROWS)-1:0]  out_row_idx
);

    localparam int unsigned FL_W  = cnt_w(ROWS + COLS);
    localparam int unsigned IDX_W = $clog2(ROWS);

    logic [1:0]             state_q, state_d;
    logic [K_W-1:0]         k_q, k_d, beat_q, beat_d;
    logic                   relu_q, relu_d;
    logic [FL_W-1:0]        flush_q, flush_d;
    logic [IDX_W-1:0]       ld_q, ld_d, idx_q, idx_d;
    logic                   out_valid_q, out_valid_d;
    logic [COLS*ACC_W-1:0]  out_row_q, out_row_d, row_mux;
    logic                   adv, clr, k_ok;

    logic [DATA_W-1:0] w_in [ROWS][COLS];
    logic [DATA_W-1:0] f_in [ROWS][COLS];
    logic [DATA_W-1:0] w_unused [ROWS];
    logic [DATA_W-1:0] f_unused [COLS];
    logic [ACC_W-1:0]  acc [ROWS][COLS];

    assign k_ok = (k_len != '0) && (k_len <= K_W'(K_MAX));
    assign clr  = (state_q == ST_IDLE) && start && k_ok;
    assign adv  = ((state_q == ST_LOAD) && in_valid) || (state_q == ST_FLUSH);

    // Row r of weights / column c of features is delayed r / c advances.
    for (genvar r = 0; r < ROWS; r++) begin : g_wsk
        logic [DATA_W-1:0] src;
        assign src = (state_q == ST_LOAD) ? w_col[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign w_in[0][0] = src;
        end else begin : g_chain
            logic [DATA_W-1:0] sk_q [r];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst || clr) begin
                    for (int unsigned i = 0; i < r; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= src;
                    for (int unsigned i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign w_in[r][0] = sk_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_fsk
        logic [DATA_W-1:0] src;
        assign src = (state_q == ST_LOAD) ? f_row[c*DATA_W +: DATA_W] : '0;
        if (c == 0) begin : g_direct
            assign f_in[0][0] = src;
        end else begin : g_chain
            logic [DATA_W-1:0] sk_q [c];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst || clr) begin
                    for (int unsigned i = 0; i < c; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= src;
                    for (int unsigned i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign f_in[0][c] = sk_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [DATA_W-1:0] w_nx, f_nx;
            sys_pe_os #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .adv_i (adv),
                .clr_i (clr),
                .w_i   (w_in[r][c]),
                .f_i   (f_in[r][c]),
                .w_o   (w_nx),
                .f_o   (f_nx),
                .acc_o (acc[r][c])
            );
            if (c < COLS-1) begin : g_wr
                assign w_in[r][c+1] = w_nx;
            end else begin : g_we
                assign w_unused[r] = w_nx;
            end
            if (r < ROWS-1) begin : g_fd
                assign f_in[r+1][c] = f_nx;
            end else begin : g_fe
                assign f_unused[c] = f_nx;
            end
        end
    end

    always_comb begin
        row_mux = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            row_mux[c*ACC_W +: ACC_W] = relu_q ? ACC_W'(relu(wide_t'(acc[ld_q][c]), ACC_W))
                                               : acc[ld_q][c];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_d      = beat_q;
        relu_d      = relu_q;
        flush_d     = flush_q;
        ld_d        = ld_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        case (state_q)
            ST_IDLE: begin
                if (start && k_ok) begin
                    state_d = ST_LOAD;
                    k_d     = k_len;
                    relu_d  = relu_en;
                    beat_d  = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + K_W'(1);
                    if (beat_d == k_q) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = flush_q + FL_W'(1);
                if (flush_q == FL_W'(ROWS + COLS - 2)) begin
                    state_d = ST_DRAIN;
                    ld_d    = '0;
                end
            end
            default: begin
                // Output register refills in the same cycle a row is taken, so rows stream back-to-back.
                if (out_valid_q && out_ready && (idx_q == IDX_W'(ROWS - 1))) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_row_d   = row_mux;
                    idx_d       = ld_q;
                    ld_d        = ld_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            beat_q      <= '0;
            relu_q      <= 1'b0;
            flush_q     <= '0;
            ld_q        <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            relu_q      <= relu_d;
            flush_q     <= flush_d;
            ld_q        <= ld_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign in_ready    = (state_q == ST_LOAD);
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_row_idx = idx_q;

endmodule

// File: tb/tb_sys_array_os.sv
// Self-checking bench for sys_array_os: table of directed tiles plus randomized tiles vs a GEMM model.
module tb_sys_array_os;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 16;
    localparam int KW = $clog2(KM+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              relu_en;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [R*DW-1:0]   w_col;
    logic [C*DW-1:0]   f_row;
    logic              out_valid;
    logic              out_ready;
    logic [C*AW-1:0]   out_row;
    logic [$clog2(R)-1:0] out_row_idx;

    sys_array_os #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .relu_en     (relu_en),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .w_col       (w_col),
        .f_row       (f_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int Wm [R][KM];
    int Fm [KM][C];
    logic [AW-1:0] got00, got33;

    typedef struct {
        string         nm;
        int            k;
        int            wk;
        int            fk;
        bit            relu;
        bit            gaps;
        bit            stall;
        bit            late;
        logic [AW-1:0] e00;
        logic [AW-1:0] e33;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain GEMM over the bench's matrices, wrapped to AW bits, optional clamp.
    function automatic logic [AW-1:0] model(input int r, input int c, input int k, input bit rl);
        int s;
        logic signed [AW-1:0] v;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += Wm[r][kk] * Fm[kk][c];
        v = AW'(s);
        if (rl && v < 0) v = '0;
        return v;
    endfunction

    task automatic fill(input int wk, input int fk);
        for (int r = 0; r < R; r++)
            for (int kk = 0; kk < KM; kk++)
                case (wk)
                    0: Wm[r][kk] = (r == kk) ? 1 : 0;
                    1: Wm[r][kk] = -1;
                    2: Wm[r][kk] = -128;
                    3: Wm[r][kk] = 2;
                    default: Wm[r][kk] = int'($urandom_range(255)) - 128;
                endcase
        for (int kk = 0; kk < KM; kk++)
            for (int c = 0; c < C; c++)
                case (fk)
                    0: Fm[kk][c] = 4*kk + c;
                    1: Fm[kk][c] = 1;
                    2: Fm[kk][c] = -128;
                    3: Fm[kk][c] = 3;
                    default: Fm[kk][c] = int'($urandom_range(255)) - 128;
                endcase
    endtask

    task automatic drive_beat(input int b);
        for (int r = 0; r < R; r++) w_col[r*DW +: DW] = DW'(Wm[r][b]);
        for (int c = 0; c < C; c++) f_row[c*DW +: DW] = DW'(Fm[b][c]);
    endtask

    task automatic run_tile(input string nm, input int k, input bit rl, input bit gaps,
                            input bit stall, input bit late);
        int beat, lat, rows, guard;
        logic [C*AW-1:0] held;
        k_len = KW'(k);
        relu_en = rl;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, " busy_after_start"}, busy, 1);
        beat = 0;
        guard = 0;
        while (beat < k && guard < 300) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    w_col = $urandom;
                    f_row = $urandom;
                    step();
                    guard++;
                end
            end
            chk({nm, " in_ready_load"}, in_ready, 1);
            in_valid = 1'b1;
            drive_beat(beat);
            step();
            beat++;
            guard++;
        end
        // Junk beats after the last one must be ignored.
        in_valid = gaps;
        w_col = $urandom;
        f_row = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
            if (lat == 1) chk({nm, " in_ready_flush"}, in_ready, 0);
        end
        chk({nm, " latency"}, lat, R + C);
        rows = 0;
        guard = 0;
        while (rows < R && guard < 100) begin
            guard++;
            if (out_valid) begin
                chk({nm, " row_idx"}, out_row_idx, rows);
                chk({nm, " in_ready_drain"}, in_ready, 0);
                for (int c = 0; c < C; c++)
                    chk($sformatf("%s r%0d c%0d", nm, rows, c), out_row[c*AW +: AW], model(rows, c, k, rl));
                if (rows == 0) got00 = out_row[0 +: AW];
                if (rows == R-1) got33 = out_row[(C-1)*AW +: AW];
                if (stall && rows == 2) begin
                    held = out_row;
                    out_ready = 1'b0;
                    repeat (5) begin
                        step();
                        chk({nm, " stall_valid"}, out_valid, 1);
                        chk({nm, " stall_idx"}, out_row_idx, 2);
                        chk({nm, " stall_row"}, out_row, held);
                    end
                    out_ready = 1'b1;
                end
                if (late && rows == R-1) begin
                    start = 1'b1;
                    k_len = KW'(1);
                end
                step();
                start = 1'b0;
                rows++;
            end else begin
                step();
            end
        end
        chk({nm, " rows_taken"}, rows, R);
        chk({nm, " idle_after_drain"}, busy, 0);
        chk({nm, " no_extra_row"}, out_valid, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{"ident",    4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,      16'd15};
        tbl[1] = '{"neg",      4, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC,   16'hFFFC};
        tbl[2] = '{"neg_relu", 4, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,      16'd0};
        tbl[3] = '{"gaps",     4, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,      16'd15};
        tbl[4] = '{"stall",    4, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,      16'd15};
        tbl[5] = '{"wrap",     4, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,      16'd0};

        rst = 1'b0;
        start = 1'b0;
        k_len = '0;
        relu_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        w_col = '0;
        f_row = '0;
        repeat (2) step();
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_row", out_row, 0);
        chk("reset out_row_idx", out_row_idx, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].wk, tbl[i].fk);
            run_tile(tbl[i].nm, tbl[i].k, tbl[i].relu, tbl[i].gaps, tbl[i].stall, tbl[i].late);
            chk({tbl[i].nm, " e00"}, got00, tbl[i].e00);
            chk({tbl[i].nm, " e33"}, got33, tbl[i].e33);
        end

        k_len = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("klen0 busy", busy, 0);
        k_len = KW'(KM + 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("klen_over busy", busy, 0);
        chk("klen_over in_ready", in_ready, 0);

        // Abort a run with reset partway through loading.
        fill(4, 4);
        k_len = KW'(4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            step();
        end
        rst = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        step();
        chk("rst hold busy", busy, 0);
        chk("rst hold out_valid", out_valid, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        fill(3, 3);
        run_tile("after_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_rst e00", got00, 16'd6);
        chk("after_rst e33", got33, 16'd6);

        for (int t = 0; t < 8; t++) begin
            fill(4, 4);
            run_tile($sformatf("rand%0d", t), int'($urandom_range(1, KM)), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
